// File: rtl/uart_debug_ctrl.sv
// uart_debug_ctrl
// Byte-level command interpreter between the UART FIFOs and the MIPS_DLX core.
// Commands popped from the RX FIFO load instruction memory ('L'), run ('R'),
// halt ('H'), single-step ('S') the core, or report its PC ('P'). Replies are
// pushed into the TX FIFO.
//
// Ports
//   clock, reset        : system clock, asynchronous active-high reset
//   rx_data, rx_empty   : RX FIFO head byte (show-ahead) and empty flag
//   rx_rd               : RX FIFO pop strobe
//   tx_data, tx_full    : byte to transmit, TX FIFO full flag
//   tx_wr               : TX FIFO push strobe
//   pc                  : core PC (PC+1 bus)
//   cpu_en, cpu_rst     : core clock enable and synchronous reset request
//   imem_we/addr/wdata  : instruction memory write port
module uart_debug_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_empty,
    output logic              rx_rd,
    output logic [7:0]        tx_data,
    input  logic              tx_full,
    output logic              tx_wr,
    input  logic [ADDR_W-1:0] pc,
    output logic              cpu_en,
    output logic              cpu_rst,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata
);

    localparam int         NB   = DATA_W / 8;
    localparam int         BC_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [7:0] CH_Q = 8'h3F;

    typedef enum logic [2:0] {
        IDLE, DECODE, LD_CNT, LD_BYTE, LD_WRITE, TX_HI, TX_LO, TX_ACK
    } state_t;

    state_t            r_state;
    logic [7:0]        r_cmd;
    logic [7:0]        r_tx_data;
    logic [7:0]        r_pc_lo;
    logic [7:0]        r_words;      // words still to load
    logic [BC_W-1:0]   r_bcnt;       // byte position inside the current word
    logic [ADDR_W-1:0] r_idx;        // word index, wraps naturally
    logic [DATA_W-1:0] r_shift;
    logic              r_step;       // cpu_en is high for a single-step pulse
    logic              r_cpu_en;
    logic              r_cpu_rst;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [DATA_W-1:0] r_imem_wdata;

    logic              w_rx_rd;
    logic              w_tx_wr;
    logic [15:0]       w_pc16;
    logic [DATA_W+7:0] w_shift_next;

    // Pop/push strobes are combinational so a byte can move on every cycle
    // the FIFO allows it, and are gated so a stalled FIFO never sees a strobe.
    assign w_rx_rd = !reset && !rx_empty &&
                     (r_state == IDLE || r_state == LD_CNT || r_state == LD_BYTE);
    // During a step pulse the ACK waits one cycle so 'K' follows the pulse.
    assign w_tx_wr = !reset && !tx_full &&
                     (r_state == TX_HI || r_state == TX_LO ||
                      (r_state == TX_ACK && !r_step));

    assign w_pc16       = 16'(pc);
    assign w_shift_next = {r_shift, rx_data};   // big-endian byte assembly

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cmd        <= 8'h00;
            r_tx_data    <= 8'h00;
            r_pc_lo      <= 8'h00;
            r_words      <= 8'h00;
            r_bcnt       <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_step       <= 1'b0;
            r_cpu_en     <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rx_rd) begin
                        r_cmd   <= rx_data;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    case (r_cmd)
                        8'h4C: begin                      // 'L'
                            r_cpu_en  <= 1'b0;
                            r_cpu_rst <= 1'b1;
                            r_state   <= LD_CNT;
                        end
                        8'h52: begin                      // 'R'
                            r_cpu_rst <= 1'b0;
                            r_cpu_en  <= 1'b1;
                            r_tx_data <= CH_K;
                            r_state   <= TX_ACK;
                        end
                        8'h48: begin                      // 'H'
                            r_cpu_en  <= 1'b0;
                            r_tx_data <= CH_K;
                            r_state   <= TX_ACK;
                        end
                        8'h53: begin                      // 'S'
                            if (!r_cpu_en && !r_cpu_rst) begin
                                r_cpu_en  <= 1'b1;
                                r_step    <= 1'b1;
                                r_tx_data <= CH_K;
                            end else begin
                                r_tx_data <= CH_Q;
                            end
                            r_state <= TX_ACK;
                        end
                        8'h50: begin                      // 'P'
                            // One sample feeds both reply bytes.
                            r_tx_data <= w_pc16[15:8];
                            r_pc_lo   <= w_pc16[7:0];
                            r_state   <= TX_HI;
                        end
                        default: begin
                            r_tx_data <= CH_Q;
                            r_state   <= TX_ACK;
                        end
                    endcase
                end
                LD_CNT: begin
                    if (w_rx_rd) begin
                        r_words <= rx_data;
                        r_idx   <= '0;
                        r_bcnt  <= '0;
                        if (rx_data == 8'h00) begin
                            r_tx_data <= CH_K;
                            r_state   <= TX_ACK;
                        end else begin
                            r_state <= LD_BYTE;
                        end
                    end
                end
                LD_BYTE: begin
                    if (w_rx_rd) begin
                        r_shift <= w_shift_next[DATA_W-1:0];
                        if (r_bcnt == BC_W'(NB - 1)) begin
                            // Strobe is registered here so it lands in LD_WRITE.
                            r_bcnt       <= '0;
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_idx;
                            r_imem_wdata <= w_shift_next[DATA_W-1:0];
                            r_state      <= LD_WRITE;
                        end else begin
                            r_bcnt <= r_bcnt + BC_W'(1);
                        end
                    end
                end
                LD_WRITE: begin
                    r_imem_we <= 1'b0;
                    r_idx     <= r_idx + ADDR_W'(1);
                    r_words   <= r_words - 8'd1;
                    if (r_words == 8'd1) begin
                        r_tx_data <= CH_K;
                        r_state   <= TX_ACK;
                    end else begin
                        r_state <= LD_BYTE;
                    end
                end
                TX_HI: begin
                    if (w_tx_wr) begin
                        r_tx_data <= r_pc_lo;
                        r_state   <= TX_LO;
                    end
                end
                TX_LO: begin
                    if (w_tx_wr) r_state <= IDLE;
                end
                TX_ACK: begin
                    if (r_step) begin
                        r_cpu_en <= 1'b0;
                        r_step   <= 1'b0;
                    end else if (w_tx_wr) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_rd      = w_rx_rd;
    assign tx_wr      = w_tx_wr;
    assign tx_data    = r_tx_data;
    assign cpu_en     = r_cpu_en;
    assign cpu_rst    = r_cpu_rst;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;

endmodule

// File: tb/tb_uart_debug_ctrl.sv
module tb_uart_debug_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_rd;
    logic [7:0]  tx_data;
    logic        tx_full;
    logic        tx_wr;
    logic [9:0]  pc;
    logic        cpu_en;
    logic        cpu_rst;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;

    uart_debug_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_rd(rx_rd),
        .tx_data(tx_data), .tx_full(tx_full), .tx_wr(tx_wr),
        .pc(pc), .cpu_en(cpu_en), .cpu_rst(cpu_rst),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata)
    );

    always #5 clock = ~clock;

    // FIFO models and event logs
    logic [7:0]  rxq[$];
    bit          pop_pend = 0;
    bit          bp_rand  = 0;
    int          cyc = 0;
    logic [7:0]  tx_log[$];
    int          tx_cyc[$];
    logic [41:0] we_log[$];
    int          we_cyc[$];
    int          pop_cyc[$];
    int          en_hi, win, last_en_cyc, mon_err;
    logic [7:0]  cmd[$];

    // reference core-control state
    bit m_en, m_rst;
    int n_cmp = 0, n_bad = 0;

    always @(posedge clock) begin
        #1;
        cyc = cyc + 1;
        if (pop_pend) begin
            if (rxq.size() != 0) void'(rxq.pop_front());
            pop_pend = 0;
        end
        rx_empty = (rxq.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rxq[0];
        if (bp_rand) tx_full = ($urandom_range(0, 2) == 0);
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (rx_rd) begin
                if (rx_empty) mon_err++;
                pop_pend = 1;
                pop_cyc.push_back(cyc);
            end
            if (tx_wr) begin
                if (tx_full) mon_err++;
                tx_log.push_back(tx_data);
                tx_cyc.push_back(cyc);
            end
            if (rx_rd && tx_wr) mon_err++;
            if (imem_we) begin
                we_log.push_back({imem_addr, imem_wdata});
                we_cyc.push_back(cyc);
                if (!cpu_rst || cpu_en || rx_rd) mon_err++;
            end
            if (cpu_en) begin
                en_hi++;
                last_en_cyc = cyc;
            end
            win++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        tx_log.delete(); tx_cyc.delete();
        we_log.delete(); we_cyc.delete();
        pop_cyc.delete();
        en_hi = 0; win = 0; last_en_cyc = -1; mon_err = 0;
    endtask

    // Push cmd[] into the RX FIFO, predict the outcome from the command
    // rules and compare everything that came out.
    task automatic run_cmd(input string nm);
        logic [7:0]  c, n;
        logic [31:0] w;
        logic [7:0]  exp_tx[$];
        logic [41:0] exp_we[$];
        bit          en_before, step_ok, timeout, chk_en, bad;
        int          exp_en;
        c = cmd[0];
        en_before = m_en;
        step_ok = 0;
        chk_en = 1;
        case (c)
            8'h4C: begin
                n = cmd[1];
                for (int i = 0; i < int'(n); i++) begin
                    w = {cmd[2+4*i], cmd[3+4*i], cmd[4+4*i], cmd[5+4*i]};
                    exp_we.push_back({10'(i), w});
                end
                m_en = 0; m_rst = 1; chk_en = 0;
                exp_tx.push_back(8'h4B);
            end
            8'h52: begin m_en = 1; m_rst = 0; chk_en = 0; exp_tx.push_back(8'h4B); end
            8'h48: begin m_en = 0; chk_en = 0; exp_tx.push_back(8'h4B); end
            8'h53: begin
                step_ok = !m_en && !m_rst;
                exp_tx.push_back(step_ok ? 8'h4B : 8'h3F);
            end
            8'h50: begin
                exp_tx.push_back(8'(pc >> 8));
                exp_tx.push_back(pc[7:0]);
            end
            default: exp_tx.push_back(8'h3F);
        endcase
        exp_en = en_before ? -1 : (step_ok ? 1 : 0);

        clear_logs();
        foreach (cmd[i]) rxq.push_back(cmd[i]);
        timeout = 1;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clock); #2;
            if (rxq.size() == 0 && !pop_pend && tx_log.size() >= exp_tx.size()) begin
                timeout = 0;
                break;
            end
        end
        repeat (4) begin @(posedge clock); #2; end

        n_cmp++;
        if (timeout) begin n_bad++; $display("FAIL %s timeout: tx=%0d bytes, required %0d", nm, tx_log.size(), exp_tx.size()); end

        n_cmp++;
        bad = (tx_log.size() != exp_tx.size());
        if (!bad) foreach (exp_tx[i]) if (tx_log[i] !== exp_tx[i]) bad = 1;
        if (bad) begin
            n_bad++;
            $display("FAIL %s tx bytes: got %p, required %p", nm, tx_log, exp_tx);
        end

        n_cmp++;
        bad = (we_log.size() != exp_we.size());
        if (!bad) foreach (exp_we[i]) if (we_log[i] !== exp_we[i]) bad = 1;
        if (bad) begin
            n_bad++;
            $display("FAIL %s imem writes: got %0d (%p), required %0d (%p)", nm, we_log.size(), we_log, exp_we.size(), exp_we);
        end

        n_cmp++;
        if (mon_err !== 0) begin n_bad++; $display("FAIL %s protocol: %0d handshake violations, required 0", nm, mon_err); end

        n_cmp++;
        if (cpu_en !== m_en || cpu_rst !== m_rst) begin
            n_bad++;
            $display("FAIL %s core ctrl: en=%b rst=%b, required en=%b rst=%b", nm, cpu_en, cpu_rst, m_en, m_rst);
        end

        if (chk_en) begin
            n_cmp++;
            if (exp_en < 0 ? (en_hi != win) : (en_hi != exp_en)) begin
                n_bad++;
                $display("FAIL %s cpu_en cycles: got %0d of %0d, required %0d", nm, en_hi, win, exp_en < 0 ? win : exp_en);
            end
        end
        if (step_ok && tx_cyc.size() > 0) begin
            n_cmp++;
            if (tx_cyc[0] <= last_en_cyc) begin
                n_bad++;
                $display("FAIL %s step order: K at cycle %0d, pulse at %0d", nm, tx_cyc[0], last_en_cyc);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; rx_empty = 1; rx_data = 8'h00; tx_full = 0; pc = '0;
        m_en = 0; m_rst = 1;
        clear_logs();
        repeat (3) @(posedge clock);
        #2 reset = 0;
        repeat (3) begin @(posedge clock); #2; end
        n_cmp++;
        if (cpu_rst !== 1'b1 || cpu_en !== 1'b0) begin n_bad++; $display("FAIL reset core: en=%b rst=%b, required en=0 rst=1", cpu_en, cpu_rst); end
        n_cmp++;
        if (tx_log.size() != 0 || tx_wr !== 1'b0 || rx_rd !== 1'b0) begin n_bad++; $display("FAIL reset strobes: tx pushes=%0d tx_wr=%b rx_rd=%b, required 0", tx_log.size(), tx_wr, rx_rd); end
        n_cmp++;
        if (imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_wdata !== 32'd0 || tx_data !== 8'h00) begin
            n_bad++; $display("FAIL reset outputs: we=%b addr=%h wdata=%h tx_data=%h, required all 0", imem_we, imem_addr, imem_wdata, tx_data);
        end
    endtask

    task automatic test_run();
        cmd = '{8'h52};
        run_cmd("run");
        n_cmp++;
        if (pop_cyc.size() < 1 || tx_cyc.size() < 1 || tx_cyc[0] - pop_cyc[0] != 2) begin
            n_bad++; $display("FAIL run latency: pop/tx cycles %p/%p, required tx 2 cycles after pop", pop_cyc, tx_cyc);
        end
    endtask

    task automatic test_load();
        cmd = '{8'h4C, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
        run_cmd("load");
        n_cmp++;
        if (pop_cyc.size() != 10 || we_cyc.size() != 2 ||
            we_cyc[0] != pop_cyc[5] + 1 || we_cyc[1] != pop_cyc[9] + 1 ||
            pop_cyc[5] != pop_cyc[2] + 3 || pop_cyc[6] != pop_cyc[5] + 2) begin
            n_bad++; $display("FAIL load timing: pops %p writes %p", pop_cyc, we_cyc);
        end
        cmd = '{8'h4C, 8'h00};
        run_cmd("load_zero");
    endtask

    task automatic test_pc_step();
        cmd = '{8'h52}; run_cmd("pre_run");
        cmd = '{8'h48}; run_cmd("halt");
        pc = 10'h2A5;
        cmd = '{8'h50}; run_cmd("pc");
        cmd = '{8'h53}; run_cmd("step");
    endtask

    task automatic test_bad_cmd();
        cmd = '{8'h00}; run_cmd("bad_byte");
        cmd = '{8'h52}; run_cmd("run2");
        cmd = '{8'h53}; run_cmd("step_running");
        cmd = '{8'h4C, 8'h00}; run_cmd("load_in_reset");
        cmd = '{8'h53}; run_cmd("step_in_reset");
    endtask

    task automatic test_backpressure();
        int rel;
        bit done;
        clear_logs();
        @(posedge clock); #2;
        tx_full = 1;
        rxq.push_back(8'h52);
        rxq.push_back(8'h48);
        repeat (20) begin @(posedge clock); #2; end
        n_cmp++;
        if (tx_log.size() != 0) begin n_bad++; $display("FAIL bp stall: %0d pushes while full, required 0", tx_log.size()); end
        n_cmp++;
        if (pop_cyc.size() != 1 || rxq.size() != 1) begin n_bad++; $display("FAIL bp pops: %0d pops (%0d left), required 1 (1 left)", pop_cyc.size(), rxq.size()); end
        rel = cyc;
        tx_full = 0;
        done = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clock); #2;
            if (tx_log.size() >= 2) begin done = 1; break; end
        end
        repeat (4) begin @(posedge clock); #2; end
        m_en = 0; m_rst = 0;
        n_cmp++;
        if (!done || tx_log.size() != 2 || tx_log[0] !== 8'h4B || tx_log[1] !== 8'h4B || tx_cyc[0] < rel) begin
            n_bad++; $display("FAIL bp release: got %p, required two 4b pushes after release", tx_log);
        end
        n_cmp++;
        if (mon_err !== 0 || cpu_en !== m_en || cpu_rst !== m_rst) begin
            n_bad++; $display("FAIL bp state: errs=%0d en=%b rst=%b, required 0 %b %b", mon_err, cpu_en, cpu_rst, m_en, m_rst);
        end
    endtask

    task automatic test_reset_midload();
        clear_logs();
        rxq.push_back(8'h4C); rxq.push_back(8'h01);
        rxq.push_back(8'hAA); rxq.push_back(8'hBB); rxq.push_back(8'hCC);
        for (int k = 0; k < 100; k++) begin
            @(posedge clock); #2;
            if (rxq.size() == 0 && !pop_pend) break;
        end
        repeat (3) begin @(posedge clock); #2; end
        reset = 1;
        #1;
        n_cmp++;
        if (cpu_rst !== 1'b1 || cpu_en !== 1'b0 || imem_we !== 1'b0 || tx_wr !== 1'b0 ||
            rx_rd !== 1'b0 || tx_data !== 8'h00 || imem_addr !== 10'd0 || imem_wdata !== 32'd0) begin
            n_bad++; $display("FAIL midload reset: en=%b rst=%b we=%b txwr=%b rxrd=%b txd=%h, required reset values", cpu_en, cpu_rst, imem_we, tx_wr, rx_rd, tx_data);
        end
        n_cmp++;
        if (pop_cyc.size() != 5 || we_log.size() != 0 || tx_log.size() != 0) begin
            n_bad++; $display("FAIL midload traffic: pops=%0d writes=%0d tx=%0d, required 5 0 0", pop_cyc.size(), we_log.size(), tx_log.size());
        end
        repeat (2) @(posedge clock);
        #2 reset = 0;
        m_en = 0; m_rst = 1;
        pc = 10'h13C;
        cmd = '{8'h50}; run_cmd("pc_after_reset");
    endtask

    task automatic test_random();
        logic [7:0] b;
        int sel, n;
        bp_rand = 1;
        for (int t = 0; t < 40; t++) begin
            pc = 10'($urandom);
            cmd.delete();
            sel = $urandom_range(0, 6);
            case (sel)
                0: begin
                    n = $urandom_range(0, 3);
                    cmd.push_back(8'h4C); cmd.push_back(8'(n));
                    for (int i = 0; i < 4 * n; i++) cmd.push_back(8'($urandom));
                end
                1: cmd.push_back(8'h52);
                2: cmd.push_back(8'h48);
                3, 4: cmd.push_back(8'h53);
                5: cmd.push_back(8'h50);
                default: begin
                    do b = 8'($urandom);
                    while (b == 8'h4C || b == 8'h52 || b == 8'h48 || b == 8'h53 || b == 8'h50);
                    cmd.push_back(b);
                end
            endcase
            run_cmd($sformatf("rand%0d_%02h", t, cmd[0]));
        end
        bp_rand = 0;
        tx_full = 0;
    endtask

    initial begin
        test_reset();
        test_run();
        test_load();
        test_pc_step();
        test_bad_cmd();
        test_backpressure();
        test_reset_midload();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
